rtc_bus_seq: RTL and testbench
==============================

Name: rtc_bus_seq

Overview:
- Consumer of the 0..21 bus-step counter. Drives the counter's enable and decodes its 5-bit step value into multiplexed address/data bus strobes for the RTC chip.
- Accepts one read or write request per handshake and returns read data with a done pulse.
- Sits between the control FSM (request side) and the RTC pins (bus side).

Parameters:
- LAST_STEP, 21, final step index of a bus cycle; must match the counter wrap value.
- SAMPLE_STEP, 17, step at which ad_in is captured on reads.
- DW, 8, address/data bus width.

Ports:
- clk  in  1  system clock; all logic on rising edge. The counter advances on the falling edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; latched with start.
- addr  in  DW  RTC register address; latched with start.
- wdata  in  DW  write data; latched with start.
- step  in  5  current step from the counter.
- cnt_en  out  1  enable to the counter.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the bus cycle completes.
- rdata  out  DW  captured read data; holds until the next read.
- cs_n, rd_n, wr_n  out  1 each  active-low bus strobes.
- ale  out  1  address latch enable.
- ad_out  out  DW  bus drive value.
- ad_oe  out  1  tristate enable for ad_out.
- ad_in  in  DW  bus sample value.

Behaviour:
- Reset values, applied on the first posedge with reset=1:
  - cs_n=rd_n=wr_n=1; ale=0; ad_oe=0; ad_out=0.
  - cnt_en=0; busy=0; done=0; rdata=0; state IDLE.
- FSM states: IDLE, RUN, FIN.
  - IDLE: when start=1, latch rw/addr/wdata, set cnt_en=1 and busy=1, go to RUN.
  - RUN: hold cnt_en=1. When the posedge sees step==LAST_STEP, clear cnt_en, go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, go to IDLE. The counter is cleared by cnt_en=0 on the following negedge.
- start is ignored unless the state is IDLE. Back-to-back requests need one IDLE cycle after done.
- Bus outputs are registered.
  - Each posedge in RUN decodes the current step; pins update on that edge, half a clock after the step changes.
  - Outside RUN, all bus outputs are at their reset (idle) values.
- Step decode in RUN (inclusive ranges):
  - cs_n=0 for steps 1..20.
  - ale=1 for steps 2..5.
  - ad_oe=1, ad_out=addr for steps 1..7.
  - Steps 8..9: ad_oe=0 (turnaround).
  - Read: rd_n=0 for steps 10..SAMPLE_STEP; ad_oe=0.
  - Write: wr_n=0 for steps 10..17; ad_oe=1, ad_out=wdata for steps 10..18.
  - Steps 19..21: all strobes inactive except cs_n per its range.
- Read capture: on the posedge where step==SAMPLE_STEP and rw=1, rdata<=ad_in. Writes leave rdata unchanged.
- Step values 22..31 (not produced by the counter): decode as idle; do not end the cycle.
- Step 0 seen in RUN (counter not yet advanced): idle decode; wait.
- Reset mid-cycle: all outputs return to reset values on that edge; no done pulse; the latched request is discarded.
- rd_n and wr_n are never low on the same cycle. ale and rd_n/wr_n never overlap.

Decomposition:
- Shared package rtc_pkg holds:
  - step constants: STEP_CS_LO=1, STEP_CS_HI=20, STEP_ALE_LO=2, STEP_ALE_HI=5, STEP_ADDR_HI=7, STEP_DATA_LO=10, STEP_DATA_HI=17, STEP_WDRV_HI=18;
  - the FSM state enum.
- One sub-module, rtc_step_decode: purely combinational mapping of (step, rw, addr, wdata) to next bus pin values. The parent registers its outputs and gates them with state==RUN.

Test Plan:
- Reset with bus pins idle, then hold start=0 for 50 cycles -> cnt_en=0, busy=0, cs_n=1, no done.
- Write addr=0x21, wdata=0x5A, with a behavioural counter on negedge ->
  - cs_n low for steps 1..20; ale high for steps 2..5; ad_out=0x21 for steps 1..7;
  - wr_n low for steps 10..17; ad_out=0x5A for steps 10..18;
  - done pulses once after step 21; rd_n stays 1.
- Read addr=0x04 with ad_in=0x37 only at step 17 (0xFF otherwise) -> rdata=0x37, ad_oe=0 during steps 8..21, wr_n stays 1.
- start pulsed again at steps 5 and 15 of a cycle -> ignored; exactly one done; latched addr unchanged.
- Assert reset at step 12 of a write -> next edge: wr_n=1, cs_n=1, cnt_en=0, busy=0; no done. A new read after reset completes normally.
- Two back-to-back reads (0x00 then 0x01, with ad_in 0x11 then 0x22) -> two done pulses separated by at least 1 IDLE cycle; rdata=0x11, then 0x22.

Source files
------------

// File: rtl/rtc_pkg.sv
// ============================================================================
// rtc_pkg: shared step-window constants and sequencer state type for the
//          RTC multiplexed-bus sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rtc_pkg;

   // Step windows within one 0..21 bus cycle (inclusive bounds)
   localparam logic [4:0] STEP_CS_LO   = 5'd1;
   localparam logic [4:0] STEP_CS_HI   = 5'd20;
   localparam logic [4:0] STEP_ALE_LO  = 5'd2;
   localparam logic [4:0] STEP_ALE_HI  = 5'd5;
   localparam logic [4:0] STEP_ADDR_HI = 5'd7;
   localparam logic [4:0] STEP_DATA_LO = 5'd10;
   localparam logic [4:0] STEP_DATA_HI = 5'd17;
   localparam logic [4:0] STEP_WDRV_HI = 5'd18;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rtc_step_decode.sv
// ============================================================================
// rtc_step_decode: combinational map from bus step and latched request to the
//                  next RTC pin values.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rtc_step_decode
   import rtc_pkg::*;
#(
   parameter int DW          = 8,
   parameter int SAMPLE_STEP = 17
) (
   input  logic [4:0]    step,
   input  logic          rw,
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          cs_n,
   output logic          rd_n,
   output logic          wr_n,
   output logic          ale,
   output logic          ad_oe,
   output logic [DW-1:0] ad_out
);

   localparam logic [4:0] SAMPLE_IDX = 5'(SAMPLE_STEP);

   logic in_cs;
   logic in_ale;
   logic in_addr;
   logic in_rd;
   logic in_wr;
   logic in_wdrv;

   // Steps 0 and 22..31 fall outside every window and so decode as idle.
   assign in_cs   = (step >= STEP_CS_LO)   && (step <= STEP_CS_HI);
   assign in_ale  = (step >= STEP_ALE_LO)  && (step <= STEP_ALE_HI);
   assign in_addr = (step >= STEP_CS_LO)   && (step <= STEP_ADDR_HI);
   assign in_rd   = (step >= STEP_DATA_LO) && (step <= SAMPLE_IDX);
   assign in_wr   = (step >= STEP_DATA_LO) && (step <= STEP_DATA_HI);
   assign in_wdrv = (step >= STEP_DATA_LO) && (step <= STEP_WDRV_HI);

   always_comb begin
      cs_n   = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      ale    = 1'b0;
      ad_oe  = 1'b0;
      ad_out = '0;

      if (in_cs) begin
         cs_n = 1'b0;
      end
      if (in_ale) begin
         ale = 1'b1;
      end

      if (in_addr) begin
         ad_oe  = 1'b1;
         ad_out = addr;
      end else if (rw) begin
         rd_n = ~in_rd;
      end else begin
         wr_n = ~in_wr;
         if (in_wdrv) begin
            ad_oe  = 1'b1;
            ad_out = wdata;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rtc_bus_seq.sv
// ============================================================================
// rtc_bus_seq: runs one RTC read/write bus cycle per request, driving the step
//              counter enable and registering the decoded bus strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rtc_bus_seq
   import rtc_pkg::*;
#(
   parameter int LAST_STEP   = 21,
   parameter int SAMPLE_STEP = 17,
   parameter int DW          = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          rw,
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic [4:0]    step,
   output logic          cnt_en,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] rdata,
   output logic          cs_n,
   output logic          rd_n,
   output logic          wr_n,
   output logic          ale,
   output logic [DW-1:0] ad_out,
   output logic          ad_oe,
   input  logic [DW-1:0] ad_in
);

   localparam logic [4:0] LAST_IDX   = 5'(LAST_STEP);
   localparam logic [4:0] SAMPLE_IDX = 5'(SAMPLE_STEP);

   state_t state;
   state_t state_nx;

   logic          rw_q;
   logic [DW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   logic          dec_cs_n;
   logic          dec_rd_n;
   logic          dec_wr_n;
   logic          dec_ale;
   logic          dec_ad_oe;
   logic [DW-1:0] dec_ad_out;

   logic          accept;
   logic          sample;

   rtc_step_decode #(
      .DW          (DW),
      .SAMPLE_STEP (SAMPLE_STEP)
   ) u_decode (
      .step   (step),
      .rw     (rw_q),
      .addr   (addr_q),
      .wdata  (wdata_q),
      .cs_n   (dec_cs_n),
      .rd_n   (dec_rd_n),
      .wr_n   (dec_wr_n),
      .ale    (dec_ale),
      .ad_oe  (dec_ad_oe),
      .ad_out (dec_ad_out)
   );

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      sample   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            sample = rw_q && (step == SAMPLE_IDX);
            if (step == LAST_IDX) begin
               state_nx = ST_FIN;
            end
         end
         ST_FIN: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Control outputs follow the next state so each lines up with the edge
   // that enters or leaves RUN/FIN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt_en  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state  <= state_nx;
         cnt_en <= (state_nx == ST_RUN);
         busy   <= (state_nx == ST_RUN);
         done   <= (state_nx == ST_FIN);
         if (accept) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (sample) begin
            rdata <= ad_in;
         end
      end
   end

   // Pins change half a clock after the counter's falling-edge step update.
   always_ff @(posedge clk) begin
      if (reset || (state != ST_RUN)) begin
         cs_n   <= 1'b1;
         rd_n   <= 1'b1;
         wr_n   <= 1'b1;
         ale    <= 1'b0;
         ad_oe  <= 1'b0;
         ad_out <= '0;
      end else begin
         cs_n   <= dec_cs_n;
         rd_n   <= dec_rd_n;
         wr_n   <= dec_wr_n;
         ale    <= dec_ale;
         ad_oe  <= dec_ad_oe;
         ad_out <= dec_ad_out;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_seq.sv
// ============================================================================
// tb_rtc_bus_seq: directed bench for rtc_bus_seq with a falling-edge model of
//                 the 0..21 step counter.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rtc_bus_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       rw;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [4:0] step = 5'd0;
   logic       cnt_en;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic       ale;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic [7:0] ad_in;
   logic [7:0] samp_val = 8'hFF;

   int total = 0;
   int bad   = 0;

   rtc_bus_seq #(
      .LAST_STEP   (21),
      .SAMPLE_STEP (17),
      .DW          (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .rw     (rw),
      .addr   (addr),
      .wdata  (wdata),
      .step   (step),
      .cnt_en (cnt_en),
      .busy   (busy),
      .done   (done),
      .rdata  (rdata),
      .cs_n   (cs_n),
      .rd_n   (rd_n),
      .wr_n   (wr_n),
      .ale    (ale),
      .ad_out (ad_out),
      .ad_oe  (ad_oe),
      .ad_in  (ad_in)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cnt_en !== 1'b1)  step <= 5'd0;
      else if (step == 5'd21) step <= 5'd0;
      else                  step <= step + 5'd1;
   end

   // The RTC only presents valid data at the sample step.
   assign ad_in = (step == 5'd17) ? samp_val : 8'hFF;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected pins after the edge that sampled step k (k=0 means idle).
   task automatic check_pins(input int k, input logic r, input logic [7:0] a, input logic [7:0] d);
      logic       e_cs_n, e_rd_n, e_wr_n, e_ale, e_oe;
      logic [7:0] e_out;
      e_cs_n = !(k >= 1 && k <= 20);
      e_ale  = (k >= 2 && k <= 5);
      e_rd_n = !(r && k >= 10 && k <= 17);
      e_wr_n = !(!r && k >= 10 && k <= 17);
      e_oe   = (k >= 1 && k <= 7) || (!r && k >= 10 && k <= 18);
      e_out  = (k >= 1 && k <= 7) ? a : ((!r && k >= 10 && k <= 18) ? d : 8'h00);
      check($sformatf("cs_n@%0d", k),   cs_n,   e_cs_n);
      check($sformatf("rd_n@%0d", k),   rd_n,   e_rd_n);
      check($sformatf("wr_n@%0d", k),   wr_n,   e_wr_n);
      check($sformatf("ale@%0d", k),    ale,    e_ale);
      check($sformatf("ad_oe@%0d", k),  ad_oe,  e_oe);
      check($sformatf("ad_out@%0d", k), ad_out, e_out);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_cnt_en"}, cnt_en, 1'b0);
      check({tag, "_busy"},   busy,   1'b0);
      check({tag, "_done"},   done,   1'b0);
      check({tag, "_rdata"},  rdata,  8'h00);
      check_pins(0, 1'b0, 8'h00, 8'h00);
   endtask

   // One full bus cycle; optional re-pulse of start at steps 5/15 and an
   // optional reset asserted on the edge that samples step abort_at.
   task automatic do_txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] sv, input bit repulse, input int abort_at,
                         input logic [7:0] exp_rdata);
      rw       = r;
      addr     = a;
      wdata    = d;
      samp_val = sv;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("accept_busy",   busy,   1'b1);
      check("accept_cnt_en", cnt_en, 1'b1);
      check("accept_done",   done,   1'b0);
      check_pins(0, r, a, d);
      for (int k = 1; k <= 21; k++) begin
         if (repulse && (k == 5 || k == 15)) begin
            start = 1'b1;
            rw    = ~r;
            addr  = 8'h7E;
            wdata = 8'h81;
         end
         if (k == abort_at) reset = 1'b1;
         tick();
         start = 1'b0;
         if (k == abort_at) begin
            reset = 1'b0;
            check_reset_state("abort");
            return;
         end
         check_pins(k, r, a, d);
         if (k < 21) begin
            check("run_done",   done,   1'b0);
            check("run_busy",   busy,   1'b1);
            check("run_cnt_en", cnt_en, 1'b1);
         end else begin
            check("fin_done",   done,   1'b1);
            check("fin_busy",   busy,   1'b0);
            check("fin_cnt_en", cnt_en, 1'b0);
         end
      end
      tick();
      check("post_done",  done,  1'b0);
      check("post_busy",  busy,  1'b0);
      check("post_rdata", rdata, exp_rdata);
      check_pins(0, r, a, d);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      rw    = 1'b0;
      addr  = 8'h00;
      wdata = 8'h00;
      tick();
      check_reset_state("reset");
      reset = 1'b0;

      for (int i = 0; i < 50; i++) begin
         tick();
         check("idle_cnt_en", cnt_en, 1'b0);
         check("idle_busy",   busy,   1'b0);
         check("idle_cs_n",   cs_n,   1'b1);
         check("idle_done",   done,   1'b0);
      end

      do_txn(1'b0, 8'h21, 8'h5A, 8'hFF, 1'b0, 0, 8'h00);
      do_txn(1'b1, 8'h04, 8'h00, 8'h37, 1'b0, 0, 8'h37);
      do_txn(1'b0, 8'h33, 8'hC3, 8'hFF, 1'b1, 0, 8'h37);
      do_txn(1'b0, 8'h44, 8'h99, 8'hFF, 1'b0, 12, 8'h00);

      for (int i = 0; i < 3; i++) begin
         tick();
         check("after_abort_done", done, 1'b0);
         check("after_abort_busy", busy, 1'b0);
         check("after_abort_cs_n", cs_n, 1'b1);
      end

      do_txn(1'b1, 8'h09, 8'h00, 8'h5C, 1'b0, 0, 8'h5C);
      do_txn(1'b1, 8'h00, 8'h00, 8'h11, 1'b0, 0, 8'h11);
      do_txn(1'b1, 8'h01, 8'h00, 8'h22, 1'b0, 0, 8'h22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
